// File: rtl/ami_block_responder.sv
// Local block-RAM responder for the two-port AMI block interface: port 0 serves 64-byte reads
// through an in-order response queue, and port 1 accepts 64-byte writebacks with no response.
package ami_block_pkg;
  localparam int AMI_NUM_PORTS = 2;
  localparam int AMI_ADDR_W    = 64;
  localparam int AMI_DATA_W    = 512;
  localparam int AMI_SIZE_W    = 32;

  typedef struct packed {
    logic                  valid;
    logic                  isWrite;
    logic [AMI_ADDR_W-1:0] addr;
    logic [AMI_DATA_W-1:0] data;
    logic [AMI_SIZE_W-1:0] size;
  } AMIRequest;

  typedef struct packed {
    logic                  valid;
    logic [AMI_DATA_W-1:0] data;
    logic [AMI_SIZE_W-1:0] size;
  } AMIResponse;
endpackage

module ami_block_responder
  import ami_block_pkg::*;
#(
  parameter int LOG_BLOCKS     = 10,
  parameter int LOG_RESP_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  AMIRequest                reqIn [AMI_NUM_PORTS],
  output logic [AMI_NUM_PORTS-1:0] reqIn_grant,
  output AMIResponse               respOut [AMI_NUM_PORTS],
  input  logic [AMI_NUM_PORTS-1:0] respOut_grant
);
  localparam int NUM_BLOCKS = 1 << LOG_BLOCKS;
  localparam int RESP_DEPTH = 1 << LOG_RESP_DEPTH;
  localparam logic [LOG_RESP_DEPTH:0] DEPTH_C = (LOG_RESP_DEPTH+1)'(RESP_DEPTH);

  function automatic logic [LOG_BLOCKS-1:0] block_index(input logic [AMI_ADDR_W-1:0] a);
    return a[LOG_BLOCKS+5:6];
  endfunction

  logic [AMI_DATA_W-1:0]     ram [NUM_BLOCKS];
  logic [AMI_DATA_W-1:0]     q_mem [RESP_DEPTH];
  logic [AMI_DATA_W-1:0]     rd_data_p1;
  logic                      vld_p1;
  logic [LOG_RESP_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [LOG_RESP_DEPTH:0]   q_count, inflight;
  logic                      grant_wr, grant_rd, pop;
  logic [LOG_BLOCKS-1:0]     wr_idx, rd_idx;

  // Fields and bits the responder deliberately ignores.
  logic unused_fields;
  assign unused_fields = ^{reqIn[0].isWrite, reqIn[0].size, reqIn[0].data,
                           reqIn[0].addr[AMI_ADDR_W-1:LOG_BLOCKS+6], reqIn[0].addr[5:0],
                           reqIn[1].isWrite, reqIn[1].size,
                           reqIn[1].addr[AMI_ADDR_W-1:LOG_BLOCKS+6], reqIn[1].addr[5:0],
                           respOut_grant[1]};

  assign wr_idx   = block_index(reqIn[1].addr);
  assign rd_idx   = block_index(reqIn[0].addr);
  assign grant_wr = reqIn[1].valid;
  assign grant_rd = reqIn[0].valid && !reqIn[1].valid && (inflight < DEPTH_C);
  assign pop      = (q_count != '0) && respOut_grant[0];
  assign reqIn_grant = {grant_wr, grant_rd};

  // Stage p0 -> p1: single RAM port, write wins; queue storage written from p1.
  always_ff @(posedge clk) begin
    if (grant_wr) begin
      ram[wr_idx] <= reqIn[1].data;
    end else if (grant_rd) begin
      rd_data_p1 <= ram[rd_idx];
    end
    if (vld_p1) begin
      q_mem[wr_ptr] <= rd_data_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      q_count  <= '0;
      inflight <= '0;
    end else begin
      vld_p1 <= grant_rd;
      if (vld_p1) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({vld_p1, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
      case ({grant_rd, pop})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Queue head presented combinationally; port 1 never responds.
  always_comb begin
    respOut[0].valid = 1'b0;
    respOut[0].data  = '0;
    respOut[0].size  = '0;
    respOut[1].valid = 1'b0;
    respOut[1].data  = '0;
    respOut[1].size  = '0;
    if (q_count != '0) begin
      respOut[0].valid = 1'b1;
      respOut[0].data  = q_mem[rd_ptr];
      respOut[0].size  = AMI_SIZE_W'(64);
    end
  end
endmodule

// File: tb/tb_ami_block_responder.sv
// Directed bench for ami_block_responder: table of write/read-back vectors plus hand-written
// sequences for backpressure, port contention, port semantics and mid-operation reset.
module tb_ami_block_responder;
  import ami_block_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  AMIRequest  req [AMI_NUM_PORTS];
  logic [1:0] req_grant;
  AMIResponse resp [AMI_NUM_PORTS];
  logic [1:0] resp_grant;

  int n_cmp = 0;
  int n_err = 0;
  int r1_bad = 0;

  always #5 clk = ~clk;

  ami_block_responder #(.LOG_BLOCKS(10), .LOG_RESP_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .reqIn(req), .reqIn_grant(req_grant),
    .respOut(resp), .respOut_grant(resp_grant)
  );

  always @(negedge clk) if (resp[1].valid !== 1'b0) r1_bad++;

  typedef struct {
    bit          do_wr;
    logic [63:0] waddr;
    logic [7:0]  wbyte;
    logic [63:0] raddr;
    logic [7:0]  rbyte;
  } vec_t;

  function automatic logic [511:0] pat(input logic [7:0] b);
    return {64{b}};
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_issue(input logic [63:0] addr, input logic [511:0] data,
                          input logic is_wr, input logic [31:0] size);
    req[1].valid = 1'b1; req[1].addr = addr; req[1].data = data;
    req[1].isWrite = is_wr; req[1].size = size;
    #1;
    check("wr_grant", 512'(req_grant[1]), 512'(1));
    step();
    req[1].valid = 1'b0;
  endtask

  // Issues a read and returns in the cycle after its grant.
  task automatic rd_issue(input logic [63:0] addr, input logic is_wr);
    bit got = 1'b0;
    req[0].valid = 1'b1; req[0].addr = addr; req[0].isWrite = is_wr;
    #1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (req_grant[0]) got = 1'b1;
      step();
    end
    req[0].valid = 1'b0;
    check("rd_grant_timeout", 512'(got), 512'(1));
  endtask

  task automatic read_expect(input string name, input logic [63:0] addr,
                             input logic [511:0] exp, input logic is_wr);
    rd_issue(addr, is_wr);
    check({name, "_lat1"}, 512'(resp[0].valid), 512'(0));
    step();
    check({name, "_valid"}, 512'(resp[0].valid), 512'(1));
    check({name, "_data"}, resp[0].data, exp);
    check({name, "_size"}, 512'(resp[0].size), 512'(64));
    step();
  endtask

  task automatic pop_expect(input string name, input logic [511:0] exp);
    for (int i = 0; i < 10 && !resp[0].valid; i++) step();
    check({name, "_valid"}, 512'(resp[0].valid), 512'(1));
    check({name, "_data"}, resp[0].data, exp);
    step();
  endtask

  vec_t vecs [7];

  initial begin
    int nxt;
    int gcount;
    vecs[0] = '{1'b1, 64'h40,    8'hA5, 64'h40,    8'hA5};
    vecs[1] = '{1'b1, 64'h10040, 8'h3C, 64'h7F,    8'h3C};
    vecs[2] = '{1'b0, 64'h0,     8'h00, 64'h40,    8'h3C};
    vecs[3] = '{1'b1, 64'h100,   8'h5A, 64'h13F,   8'h5A};
    vecs[4] = '{1'b1, 64'hFFC0,  8'h77, 64'h3FFC0, 8'h77};
    vecs[5] = '{1'b1, 64'h40000, 8'h11, 64'h0,     8'h11};
    vecs[6] = '{1'b0, 64'h0,     8'h00, 64'h7FFF_0040, 8'h3C};

    rst = 1'b1;
    for (int p = 0; p < AMI_NUM_PORTS; p++) req[p] = '0;
    resp_grant = 2'b11;
    step(); step();
    rst = 1'b0;
    #1;
    check("reset_grant", 512'(req_grant), 512'(0));
    check("reset_resp0_valid", 512'(resp[0].valid), 512'(0));
    check("reset_resp1_valid", 512'(resp[1].valid), 512'(0));
    step();

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].do_wr) wr_issue(vecs[v].waddr, pat(vecs[v].wbyte), 1'b1, 32'd64);
      read_expect($sformatf("vec%0d", v), vecs[v].raddr, pat(vecs[v].rbyte), 1'b0);
    end

    // Backpressure: consumer stalled, exactly four reads accepted.
    for (int i = 10; i < 16; i++) wr_issue(64'(i) << 6, pat(8'(8'h10 + i)), 1'b1, 32'd64);
    resp_grant = 2'b10;
    nxt = 10; gcount = 0;
    req[0].valid = 1'b1; req[0].isWrite = 1'b0; req[0].addr = 64'(nxt) << 6;
    #1;
    for (int c = 0; c < 8; c++) begin
      if (req_grant[0]) begin gcount++; nxt++; end
      step();
      req[0].addr = 64'(nxt) << 6;
      #1;
    end
    check("bp_grant_count", 512'(gcount), 512'(4));
    check("bp_grant_low", 512'(req_grant[0]), 512'(0));
    resp_grant = 2'b11;
    #1;
    check("bp_head_data", resp[0].data, pat(8'h1A));
    check("bp_no_same_cycle_grant", 512'(req_grant[0]), 512'(0));
    step();
    resp_grant = 2'b10;
    #1;
    check("bp_grant_after_pop", 512'(req_grant[0]), 512'(1));
    step();
    req[0].valid = 1'b0;
    resp_grant = 2'b11;
    for (int k = 11; k < 15; k++) pop_expect($sformatf("bp_order%0d", k), pat(8'(8'h10 + k)));
    step();
    check("bp_drained", 512'(resp[0].valid), 512'(0));

    // Contention: write and read to the same block in one cycle.
    req[1].valid = 1'b1; req[1].addr = 64'h80; req[1].data = 512'h1;
    req[1].isWrite = 1'b1; req[1].size = 32'd64;
    req[0].valid = 1'b1; req[0].addr = 64'h80; req[0].isWrite = 1'b0;
    #1;
    check("cont_wr_first", 512'(req_grant), 512'(2'b10));
    step();
    req[1].valid = 1'b0;
    #1;
    check("cont_rd_next", 512'(req_grant), 512'(2'b01));
    step();
    req[0].valid = 1'b0;
    step();
    check("cont_valid", 512'(resp[0].valid), 512'(1));
    check("cont_data", resp[0].data, 512'h1);
    step();

    // Port semantics: isWrite and size ignored, full-block access by port.
    wr_issue(64'h200, {16{32'hDEADBEEF}}, 1'b0, 32'd8);
    read_expect("sem", 64'h200, {16{32'hDEADBEEF}}, 1'b1);

    // Reset with three responses queued, plus a read presented in the reset cycle.
    resp_grant = 2'b10;
    req[0].valid = 1'b1; req[0].isWrite = 1'b0;
    for (int i = 10; i < 13; i++) begin
      req[0].addr = 64'(i) << 6;
      #1;
      check("rst_pre_grant", 512'(req_grant[0]), 512'(1));
      step();
    end
    req[0].valid = 1'b0;
    step(); step();
    check("rst_pre_queued", 512'(resp[0].valid), 512'(1));
    rst = 1'b1;
    req[0].valid = 1'b1; req[0].addr = 64'h40;
    step();
    rst = 1'b0;
    req[0].valid = 1'b0;
    #1;
    check("rst_post_valid", 512'(resp[0].valid), 512'(0));
    req[0].valid = 1'b1;
    for (int i = 10; i < 14; i++) begin
      req[0].addr = 64'(i) << 6;
      #1;
      check("rst_new_grant", 512'(req_grant[0]), 512'(1));
      step();
    end
    req[0].addr = 64'(14) << 6;
    #1;
    check("rst_grant_cap", 512'(req_grant[0]), 512'(0));
    req[0].valid = 1'b0;
    resp_grant = 2'b11;
    for (int k = 10; k < 14; k++) pop_expect($sformatf("rst_order%0d", k), pat(8'(8'h10 + k)));
    step();
    check("rst_drained", 512'(resp[0].valid), 512'(0));

    check("resp1_never_valid", 512'(r1_bad), 512'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ami_block_responder.md
# ami_block_responder

Memory-side responder for the two-port AMI block interface driven by the block buffer. Port 0 carries 64-byte block reads; port 1 carries 64-byte block writebacks. Requests are serviced from an on-chip block RAM, and read data is returned through an in-order response queue. It sits wherever a block-buffered app is bound to local memory rather than to the shell memory system, and serves as the bench memory model for block-buffer verification.

## Interface
- LOG_BLOCKS, 10: RAM holds 2^LOG_BLOCKS blocks of 512 bits.
- LOG_RESP_DEPTH, 2: response queue depth is 2^LOG_RESP_DEPTH; this also caps outstanding reads.
- clk  in  1  clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- reqIn  in  AMIRequest[AMI_NUM_PORTS]  [0] is the read port; [1] is the write port.
- reqIn_grant  out  1[AMI_NUM_PORTS]  combinational accept, same cycle as valid.
- respOut  out  AMIResponse[AMI_NUM_PORTS]  [0] carries read data; [1] is never valid.
- respOut_grant  in  1[AMI_NUM_PORTS]  consumer pops respOut[0] when both valid and grant are high.

## Operation
- Operation is selected by port:
  - Port 0 is always a read; port 1 is always a write.
  - The isWrite field is ignored.
  - size is ignored; every access is a full 512-bit block.
- Block index is addr[LOG_BLOCKS+5:6].
  - addr[5:0] is ignored.
  - addr bits above LOG_BLOCKS+5 are ignored, so addresses alias modulo 2^LOG_BLOCKS blocks.
- Single-ported RAM: at most one access per cycle.
- Write path:
  - reqIn_grant[1] = reqIn[1].valid. Writes are always accepted and take priority.
  - On grant, RAM[index] <= reqIn[1].data.
  - Writes produce no response.
- Read path:
  - reqIn_grant[0] = reqIn[0].valid && !reqIn[1].valid && (inflight < 2^LOG_RESP_DEPTH).
  - On grant, the RAM is read, and the registered data is enqueued one cycle later as {valid:1, data:block, size:64}.
- inflight counter (LOG_RESP_DEPTH+1 bits):
  - +1 on read grant.
  - -1 on pop (respOut[0].valid && respOut_grant[0]).
  - Both in the same cycle: unchanged.
  - Because grant is gated on inflight, the queue never overflows.
- respOut[0]:
  - When the queue is non-empty: the queue head.
  - When empty: {valid:0, data:0, size:0}.
  - respOut_grant[0] while respOut[0] is invalid is ignored.
- respOut[1] is constant {valid:0, data:0, size:0}. respOut_grant[1] is ignored.
- Ordering:
  - Responses return in read-grant order.
  - A write granted in cycle N is visible to any read granted in cycle N+1 or later.
- rst:
  - Clears inflight, the queue, and the RAM read pipeline register.
  - Does not clear RAM contents. Simulation initializes the RAM to zero.
  - Reset mid-operation discards all in-flight and queued read responses. A read granted in the reset cycle is dropped.

## Timing
- Grants are combinational from valid and internal state. The requester must hold a request until it is granted.
- Read latency:
  - Grant at cycle N.
  - RAM data registered at N+1 and enqueued at the end of N+1.
  - respOut[0].valid is high at N+2 at the earliest.
  - Later if older responses are still queued.
- Throughput:
  - One read per cycle while the consumer pops every cycle and no writes are present.
  - With the consumer stalled, at most 2^LOG_RESP_DEPTH reads are accepted; then reqIn_grant[0] stays low until a pop.
  - A pop in cycle M permits a new read grant in cycle M+1, since inflight is registered.
- Simultaneous reqIn[0].valid and reqIn[1].valid: the write is granted and the read waits at least one cycle.
- Outputs after reset:
  - reqIn_grant[*] = 0 unless the corresponding valid is high.
  - respOut[*].valid = 0.
  - inflight = 0.

## Test plan
- Write then read back:
  - Stimulus: write block addr 0x40 with data 0xA5 repeated; next cycle read addr 0x40.
  - Required: respOut[0] at grant+2 returns the 0xA5 pattern, size 64.
- Aliasing and offset bits, LOG_BLOCKS=10:
  - Stimulus: write to addr 0x10040; read addr 0x7F, then addr 0x40.
  - Required: both reads return the written data.
- Backpressure:
  - Stimulus: hold respOut_grant[0]=0 with reads valid every cycle.
  - Required: exactly 4 grants (LOG_RESP_DEPTH=2), then grant low. Raise respOut_grant[0] for one cycle: one pop, one new grant the following cycle, and order preserved.
- Port contention:
  - Stimulus: assert a read of addr 0x80 and a write of addr 0x80 (data 0x1) in the same cycle.
  - Required: the write is granted first, the read one cycle later, and the read returns 0x1.
- Port semantics:
  - Stimulus: write port with isWrite=0 and size=8; read port with isWrite=1.
  - Required: the port-1 request writes the full block. The port-0 request is a read with a response. respOut[1].valid stays 0 throughout.
- Reset mid-operation:
  - Stimulus: assert rst with 3 responses queued.
  - Required: the cycle after, respOut[0].valid=0, and 4 new reads can be granted. RAM contents written before rst still read back correctly.
